// File: rtl/dmem_arb_pkg.sv
// Shared types and helpers for the data-memory arbiter between the CPU MEM
// stage and the debug/loader port.
package dmem_arb_pkg;

  localparam int unsigned ARB_ADDR_WIDTH = 32;
  localparam int unsigned ARB_DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    CPU_PRI = 2'd0,
    DBG_PRI = 2'd1,
    HALTED  = 2'd2
  } arb_state_t;

  typedef enum logic {
    PORT_CPU = 1'b0,
    PORT_DBG = 1'b1
  } port_id_t;

  typedef struct packed {
    logic                      we;
    logic [ARB_ADDR_WIDTH-1:0] addr;
    logic [ARB_DATA_WIDTH-1:0] wdata;
  } mem_req_t;

  // A byte address is usable only if word aligned and inside the array.
  function automatic logic addr_legal(input logic [ARB_ADDR_WIDTH-1:0] addr,
                                      input int unsigned depth);
    return (addr[1:0] == 2'b00) && ((addr >> 2) < ARB_ADDR_WIDTH'(depth));
  endfunction

endpackage

// File: rtl/dmem_arb_fsm.sv
// Arbitration state, debug-port starvation counter and combinational grants.
module dmem_arb_fsm
  import dmem_arb_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cpu_req,
  input  logic       dbg_req,
  input  logic       dbg_halt,
  output logic       cpu_gnt,
  output logic       dbg_gnt,
  output arb_state_t state
);

  localparam logic [3:0] LIMIT    = 4'(STARVE_LIMIT);
  localparam logic [3:0] LIMIT_M1 = 4'(STARVE_LIMIT - 1);

  arb_state_t state_q, state_d;
  logic [3:0] starve_cnt, starve_d;

  // Grants are forced low while reset is held so no output toggles in reset.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so
    // no path leaves it unassigned and no latch is inferred.
    cpu_gnt = 1'b0;
    dbg_gnt = 1'b0;
    if (rst_n) begin
      case (state_q)
        CPU_PRI: begin
          cpu_gnt = cpu_req;
          dbg_gnt = dbg_req & ~cpu_req;
        end
        DBG_PRI: begin
          dbg_gnt = dbg_req;
          cpu_gnt = cpu_req & ~dbg_req;
        end
        HALTED:  dbg_gnt = dbg_req;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    if (dbg_halt)
      state_d = HALTED;
    else if (state_q == HALTED)
      state_d = CPU_PRI;
    else if (state_q == CPU_PRI && starve_cnt == LIMIT_M1 && dbg_req && !dbg_gnt)
      state_d = DBG_PRI;
    else if (state_q == DBG_PRI && dbg_gnt)
      state_d = CPU_PRI;
  end

  always_comb begin
    starve_d = starve_cnt;
    if (!dbg_req || dbg_gnt)
      starve_d = 4'd0;
    else if (starve_cnt != LIMIT)
      starve_d = starve_cnt + 4'd1;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= CPU_PRI;
      starve_cnt <= 4'd0;
    end else begin
      state_q    <= state_d;
      starve_cnt <= starve_d;
    end
  end

  assign state = state_q;

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one synchronous data memory between the CPU MEM stage and a
// debug/loader port: request mux, address check and read-return routing.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = ARB_DATA_WIDTH,
  parameter int unsigned MEM_DEPTH    = 32,
  parameter int unsigned ADDR_WIDTH   = ARB_ADDR_WIDTH,
  parameter int unsigned STARVE_LIMIT = 4,
  localparam int unsigned IDX_W       = $clog2(MEM_DEPTH)
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic                  i_cpu_req,
  input  logic                  i_cpu_we,
  input  logic [ADDR_WIDTH-1:0] i_cpu_addr,
  input  logic [DATA_WIDTH-1:0] i_cpu_wdata,
  output logic                  o_cpu_gnt,
  output logic                  o_cpu_stall,
  output logic                  o_cpu_rvalid,
  output logic [DATA_WIDTH-1:0] o_cpu_rdata,
  output logic                  o_cpu_err,
  input  logic                  i_dbg_req,
  input  logic                  i_dbg_we,
  input  logic [ADDR_WIDTH-1:0] i_dbg_addr,
  input  logic [DATA_WIDTH-1:0] i_dbg_wdata,
  input  logic                  i_dbg_halt,
  output logic                  o_dbg_gnt,
  output logic                  o_dbg_rvalid,
  output logic [DATA_WIDTH-1:0] o_dbg_rdata,
  output logic                  o_dbg_err,
  output logic                  o_halted,
  output logic                  o_mem_en,
  output logic                  o_mem_we,
  output logic [IDX_W-1:0]      o_mem_addr,
  output logic [DATA_WIDTH-1:0] o_mem_wdata,
  input  logic [DATA_WIDTH-1:0] i_mem_rdata
);

  arb_state_t state;
  logic       cpu_gnt, dbg_gnt, any_gnt;
  mem_req_t   cpu_bus, dbg_bus, win;
  logic       win_legal, store_err, load_gnt;
  logic       rd_valid, rd_err;
  port_id_t   rd_port;

  dmem_arb_fsm #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_fsm (
    .clk      (i_clk),
    .rst_n    (i_reset_n),
    .cpu_req  (i_cpu_req),
    .dbg_req  (i_dbg_req),
    .dbg_halt (i_dbg_halt),
    .cpu_gnt  (cpu_gnt),
    .dbg_gnt  (dbg_gnt),
    .state    (state)
  );

  assign cpu_bus = '{we: i_cpu_we, addr: ARB_ADDR_WIDTH'(i_cpu_addr),
                     wdata: ARB_DATA_WIDTH'(i_cpu_wdata)};
  assign dbg_bus = '{we: i_dbg_we, addr: ARB_ADDR_WIDTH'(i_dbg_addr),
                     wdata: ARB_DATA_WIDTH'(i_dbg_wdata)};
  assign any_gnt = cpu_gnt | dbg_gnt;

  // With no winner the bus is all zeros, which keeps memory outputs quiet.
  always_comb begin
    win = '0;
    if (cpu_gnt)
      win = cpu_bus;
    else if (dbg_gnt)
      win = dbg_bus;
  end

  assign win_legal = addr_legal(win.addr, MEM_DEPTH);
  assign store_err = any_gnt & win.we & ~win_legal;
  assign load_gnt  = any_gnt & ~win.we;

  assign o_mem_en    = any_gnt & win_legal;
  assign o_mem_we    = any_gnt & win.we;
  assign o_mem_addr  = win.addr[IDX_W+1:2];
  assign o_mem_wdata = DATA_WIDTH'(win.wdata);

  // Single return tag: memory latency is one cycle, so one slot suffices.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      rd_valid <= 1'b0;
      rd_err   <= 1'b0;
      rd_port  <= PORT_CPU;
    end else begin
      rd_valid <= load_gnt;
      rd_err   <= load_gnt & ~win_legal;
      rd_port  <= dbg_gnt ? PORT_DBG : PORT_CPU;
    end
  end

  assign o_cpu_rvalid = rd_valid & (rd_port == PORT_CPU);
  assign o_dbg_rvalid = rd_valid & (rd_port == PORT_DBG);
  assign o_cpu_rdata  = (o_cpu_rvalid & ~rd_err) ? i_mem_rdata : '0;
  assign o_dbg_rdata  = (o_dbg_rvalid & ~rd_err) ? i_mem_rdata : '0;

  // Store errors flag in the grant cycle, load errors ride with rvalid.
  assign o_cpu_err = (store_err & cpu_gnt) | (o_cpu_rvalid & rd_err);
  assign o_dbg_err = (store_err & dbg_gnt) | (o_dbg_rvalid & rd_err);

  assign o_cpu_gnt   = cpu_gnt;
  assign o_dbg_gnt   = dbg_gnt;
  assign o_cpu_stall = i_cpu_req & ~cpu_gnt & i_reset_n;
  assign o_halted    = (state == HALTED);

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single data memory between two requesters: the CPU MEM stage (port C) and a debug/loader port (port D).
- Port D lets a bench or host preload and inspect data memory without hierarchical references.
- Port D can halt CPU memory access.
- Sits between data_path's MEM stage and the data memory array. It holds the arbitration FSM, the starvation counter and read-return routing.

Parameters:
DATA_WIDTH, 32, data word width
MEM_DEPTH, 32, memory depth in words
ADDR_WIDTH, 32, byte-address width on both requester ports
STARVE_LIMIT, 4, consecutive denied port-D cycles before port D gets priority (1..15)

Ports:
i_clk  in  1  clock, all logic on posedge
i_reset_n  in  1  asynchronous active-low reset
i_cpu_req  in  1  CPU access request (level, held until granted)
i_cpu_we  in  1  1=store, 0=load
i_cpu_addr  in  ADDR_WIDTH  CPU byte address
i_cpu_wdata  in  DATA_WIDTH  CPU store data
o_cpu_gnt  out  1  CPU request accepted this cycle
o_cpu_stall  out  1  i_cpu_req & ~o_cpu_gnt; freezes the pipeline
o_cpu_rvalid  out  1  CPU load data valid
o_cpu_rdata  out  DATA_WIDTH  CPU load data
o_cpu_err  out  1  pulse with rvalid/accept on a bad address
i_dbg_req, i_dbg_we, i_dbg_addr, i_dbg_wdata  in  1/1/ADDR_WIDTH/DATA_WIDTH  debug request, same semantics as the CPU port
i_dbg_halt  in  1  level; blocks all CPU grants
o_dbg_gnt, o_dbg_rvalid, o_dbg_rdata, o_dbg_err  out  1/1/DATA_WIDTH/1  debug equivalents
o_halted  out  1  FSM in HALTED state
o_mem_en, o_mem_we  out  1/1  memory strobe and write enable
o_mem_addr  out  $clog2(MEM_DEPTH)  word index = addr[.. :2]
o_mem_wdata  out  DATA_WIDTH  write data
i_mem_rdata  in  DATA_WIDTH  synchronous memory read data, 1-cycle latency

Behaviour:
- Grants are combinational from the requests and the registered state. A transaction occurs when req & gnt; at most one per cycle.
- FSM states:
  - CPU_PRI (reset state): both requesting -> CPU wins.
  - DBG_PRI: both requesting -> D wins.
  - HALTED: CPU is never granted; D is granted whenever it requests.
- Transitions, registered, evaluated in priority order:
  - i_dbg_halt=1 -> HALTED.
  - HALTED with i_dbg_halt=0 -> CPU_PRI.
  - CPU_PRI with starve_cnt==STARVE_LIMIT-1 and D denied this cycle -> DBG_PRI.
  - DBG_PRI with a D grant -> CPU_PRI.
- starve_cnt (4-bit):
  - Increments each cycle D requests and is denied.
  - Clears on any D grant, or when i_dbg_req=0.
  - Saturates at STARVE_LIMIT.
- Memory drive:
  - o_mem_en = any grant with a legal address.
  - o_mem_we = the winner's we.
  - o_mem_addr and o_mem_wdata are muxed from the winner.
- Address checking:
  - Legal iff addr[1:0]==0 and addr>>2 < MEM_DEPTH.
  - Illegal access is still granted, but o_mem_en=0.
  - An illegal store is dropped; o_*_err pulses in the grant cycle.
  - An illegal load returns rdata=0 with err=1 alongside rvalid.
- Read return:
  - rvalid is asserted exactly 1 cycle after a load grant, to the granted port only. Ownership is held in a registered tag.
  - rdata is driven from i_mem_rdata, or 0 on error.
  - rdata is 0 when rvalid=0.
  - Stores produce no rvalid.
- Back-to-back loads from alternating ports each return on their own port in order; there is no buffering beyond the one tag.
- Reset mid-transaction:
  - All outputs go to 0 (o_cpu_stall = 0 during reset).
  - State -> CPU_PRI; starve_cnt and the tag clear.
  - A pending rvalid is discarded and never emitted.
- i_dbg_halt asserted while the CPU is requesting: that cycle still arbitrates under the old state, and the CPU stalls from the next cycle on.

Decomposition:
- Package dmem_arb_pkg:
  - typedef enum arb_state_t {CPU_PRI, DBG_PRI, HALTED}.
  - typedef enum port_id_t {PORT_CPU, PORT_DBG}.
  - Struct mem_req_t {we, addr, wdata}.
  - Function addr_legal().
- One sub-module, dmem_arb_fsm: state register, starve counter and grant logic.
- The top module does the request mux, address check and read-return routing.

Test Plan:
- CPU-only store then load: CPU sw 0xDEADBEEF @0x10, then lw 0x10 -> gnt the same cycle; o_mem_addr=4; o_cpu_rvalid 1 cycle after the lw with rdata 0xDEADBEEF; stall never asserted.
- Contention with starvation: both request continuously, STARVE_LIMIT=4 -> CPU granted cycles 0-3; D granted cycle 4 with CPU stall=1; CPU regains grants at cycle 5; starve_cnt=0.
- Halt: assert i_dbg_halt while the CPU is requesting -> o_halted=1 next cycle; CPU stall held high; D writes 0x12345678 @0x0, CPU is blocked. Deassert -> CPU load @0x0 returns 0x12345678.
- Bad addresses: CPU lw @0x80 (MEM_DEPTH=32) and sw @0x06 -> gnt=1, o_mem_en=0, err=1; the lw returns rvalid with rdata=0; memory is unchanged.
- Alternating loads: C lw @0x4, D lw @0x8 on consecutive cycles, memory preloaded with 0xA and 0xB -> o_cpu_rdata=0xA, then the next cycle o_dbg_rdata=0xB; no cross-delivery.
- Reset mid-load: grant a CPU lw, then pull i_reset_n low before the next edge -> no rvalid; all outputs 0; state CPU_PRI after release.
